// File: rtl/fnd_scan_controller.sv
// fnd_scan_controller
//   Turns a 14-bit binary value into four BCD digits with a sequential
//   shift-add-3 (double-dabble) engine. The committed result is held in a
//   display register. The digit slot is scanned at a programmable rate for a
//   4-digit seven-segment display.
//
// Parameters
//   P_SCAN_DIV : clock cycles per digit slot (>= 2)
//   P_BLANK_LZ : 1 = blank leading zeros on digits 3..1
//
// Ports
//   i_clk            : system clock, rising edge
//   i_reset_n        : asynchronous active-low reset
//   i_value[13:0]    : binary value to display (0..9999, larger values clamp)
//   i_load           : one-cycle strobe, capture i_value and convert
//   i_En             : global display enable
//   o_busy           : conversion in progress, loads are dropped
//   o_overflow       : last committed value was clamped to 9999
//   o_digit_position : current digit slot, 0 = least significant
//   o_value[3:0]     : BCD digit for the current slot (0 when blanked)
//   o_En             : slot enable (i_En and not blanked)
module fnd_scan_controller #(
  parameter int P_SCAN_DIV = 100000,
  parameter bit P_BLANK_LZ = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [13:0] i_value,
  input  logic        i_load,
  input  logic        i_En,
  output logic        o_busy,
  output logic        o_overflow,
  output logic [1:0]  o_digit_position,
  output logic [3:0]  o_value,
  output logic        o_En
);

  localparam int PW = $clog2(P_SCAN_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(P_SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [3:0]    bit_cnt;
  logic          ovf;
  logic [13:0]   bin_sr;
  logic [15:0]   bcd_sr;
  logic [15:0]   disp;
  logic [PW-1:0] presc;
  logic [1:0]    digit;
  logic          tick;
  logic [3:0]    lead_zero;
  logic [3:0]    nibble;
  logic          blank;

  function automatic logic [13:0] clamp_value(input logic [13:0] v);
    return (v > 14'd9999) ? 14'd9999 : v;
  endfunction

  // One double-dabble correction: every nibble >= 5 gets +3 so the
  // following left shift carries correctly into the next decimal digit.
  function automatic logic [15:0] add3_nibbles(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int k = 0; k < 4; k++) begin
      if (b[k*4 +: 4] >= 4'd5) r[k*4 +: 4] = b[k*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Conversion FSM: state register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // Conversion FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_load) state_nxt = SHIFT;
      SHIFT:   if (bit_cnt == 4'd13) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Conversion control and display register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      bit_cnt    <= 4'd0;
      ovf        <= 1'b0;
      o_overflow <= 1'b0;
      disp       <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (i_load) begin
            bit_cnt <= 4'd0;
            ovf     <= (i_value > 14'd9999);
          end
        end
        SHIFT:   bit_cnt <= bit_cnt + 4'd1;
        COMMIT: begin
          disp       <= bcd_sr;
          o_overflow <= ovf;
        end
        default: ;
      endcase
    end
  end

  // Shift-add-3 datapath; contents only matter between load and commit
  always_ff @(posedge i_clk) begin
    if (state == IDLE && i_load) begin
      bin_sr <= clamp_value(i_value);
      bcd_sr <= 16'd0;
    end else if (state == SHIFT) begin
      {bcd_sr, bin_sr} <= {add3_nibbles(bcd_sr), bin_sr} << 1;
    end
  end

  // Scan prescaler and digit counter; wrap and advance share one edge
  assign tick = (presc == PRESC_LAST);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      presc <= '0;
      digit <= 2'd0;
    end else if (tick) begin
      presc <= '0;
      digit <= digit + 2'd1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Output selection and leading-zero blanking
  always_comb begin
    lead_zero    = 4'b0000;
    lead_zero[3] = (disp[15:12] == 4'd0);
    lead_zero[2] = lead_zero[3] && (disp[11:8] == 4'd0);
    lead_zero[1] = lead_zero[2] && (disp[7:4] == 4'd0);
    nibble       = disp[digit*4 +: 4];
    blank        = P_BLANK_LZ && lead_zero[digit];
  end

  assign o_busy           = (state != IDLE);
  assign o_digit_position = digit;
  assign o_value          = blank ? 4'd0 : nibble;
  assign o_En             = i_En && !blank;

endmodule

// File: tb/tb_fnd_scan_controller.sv
module tb_fnd_scan_controller;

  logic        clk;
  logic        rst_n;
  logic [13:0] value;
  logic        load;
  logic        en;
  logic        busy;
  logic        overflow;
  logic [1:0]  pos;
  logic [3:0]  dval;
  logic        den;

  int vectors;
  int miscompares;

  fnd_scan_controller #(.P_SCAN_DIV(4), .P_BLANK_LZ(1'b1)) dut (
    .i_clk            (clk),
    .i_reset_n        (rst_n),
    .i_value          (value),
    .i_load           (load),
    .i_En             (en),
    .o_busy           (busy),
    .o_overflow       (overflow),
    .o_digit_position (pos),
    .o_value          (dval),
    .o_En             (den)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Strobe a load and return how many sampled cycles o_busy stayed high.
  task automatic do_load(input logic [13:0] v, output int busy_n);
    @(negedge clk);
    value = v;
    load  = 1'b1;
    @(negedge clk);
    load   = 1'b0;
    busy_n = 0;
    while (busy && busy_n < 40) begin
      busy_n++;
      @(negedge clk);
    end
  endtask

  // Visit each slot 0..3 and compare against hand-written digit values
  // (already zeroed where blanked) and enable mask.
  task automatic check_display(input string tag, input logic [15:0] vals, input logic [3:0] ens);
    int n;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (pos != k[1:0] && n < 50) begin
        n++;
        @(negedge clk);
      end
      chk($sformatf("%s_pos%0d", tag, k), pos, k);
      chk($sformatf("%s_val%0d", tag, k), dval, vals[k*4 +: 4]);
      chk($sformatf("%s_en%0d", tag, k), den, ens[k]);
    end
  endtask

  initial begin
    int bn;
    int n;
    logic [1:0] s;
    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0;
    value = '0;
    load  = 1'b0;
    en    = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_pos", pos, 0);
    chk("rst_val", dval, 0);
    chk("rst_en", den, 1);
    rst_n = 1'b1;

    // 1234: 15 busy cycles, all digits shown, 4-cycle slots
    do_load(14'd1234, bn);
    chk("busy_len_1234", bn, 15);
    check_display("d1234", 16'h1234, 4'b1111);
    s = pos;
    n = 0;
    while (pos == s && n < 20) begin n++; @(negedge clk); end
    s = pos;
    n = 0;
    while (pos == s && n < 20) begin n++; @(negedge clk); end
    chk("slot_hold", n, 4);

    // Leading-zero blanking
    do_load(14'd7, bn);
    check_display("d7", 16'h0007, 4'b0001);
    do_load(14'd0, bn);
    check_display("d0", 16'h0000, 4'b0001);

    // Clamp and clear of overflow
    do_load(14'd12000, bn);
    chk("ovf_set", overflow, 1);
    check_display("d12000", 16'h9999, 4'b1111);
    do_load(14'd42, bn);
    chk("ovf_clr", overflow, 0);
    check_display("d42", 16'h0042, 4'b0011);

    // Load while busy is dropped
    @(negedge clk);
    value = 14'd5000;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_mid", busy, 1);
    value = 14'd321;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    n = 0;
    while (busy && n < 40) begin n++; @(negedge clk); end
    chk("drop_busy_end", n, 10);
    repeat (20) @(negedge clk);
    check_display("d5000", 16'h5000, 4'b1111);

    // Global enable low: rotation continues, every slot disabled
    en = 1'b0;
    check_display("en_off", 16'h5000, 4'b0000);
    en = 1'b1;

    // Reset in the middle of SHIFT
    @(negedge clk);
    value = 14'd9999;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pos", pos, 0);
    chk("mid_rst_val", dval, 0);
    chk("mid_rst_en", den, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_busy", busy, 0);
    check_display("post_rst", 16'h0000, 4'b0001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
